// File: rtl/argo_fifo.sv
// Single-clock first-word-fall-through FIFO used as the Argo channel primitive.
// Define ARGO_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module argo_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef ARGO_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] rp;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags come from the occupancy counter so wp == rp is never ambiguous.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign wr_acc  = wr_en && !full;
  assign rd_acc  = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wp <= wp + 1'b1;
      if (rd_acc) rp <= rp + 1'b1;
      if (wr_acc && !rd_acc)
        count <= count + 1'b1;
      else if (!wr_acc && rd_acc)
        count <= count - 1'b1;
    end
  end

  // Storage is never cleared; reset only blocks a write on the same edge.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wp] <= wr_data;
  end

`ifdef ARGO_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_argo_fifo.sv
// Self-checking bench for argo_fifo: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_argo_fifo;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
`ifdef ARGO_FIFO_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  argo_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_data(rd_data),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty), .count(count)
`ifdef ARGO_FIFO_ERR_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] q[$];
  bit ovf_m = 0;
  bit unf_m = 0;

  // Drive one clock of stimulus and advance the reference model.
  task automatic cycle(input bit we, input logic [DW-1:0] wd, input bit re);
    int sz;
    wr_en = we; wr_data = wd; rd_en = re;
    @(posedge clk);
    sz = q.size();
    if (we && sz == DEPTH) ovf_m = 1;
    if (re && sz == 0) unf_m = 1;
    if (re && sz > 0) void'(q.pop_front());
    if (we && sz < DEPTH) q.push_back(wd);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    q.delete(); ovf_m = 0; unf_m = 0;
    #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cycle(0, '0, 0);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
`ifdef ARGO_FIFO_ERR_EN
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b%0b exp=00", overflow, underflow); end
`endif
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_v;
    cycle(1, 5, 0); cycle(1, 6, 0); cycle(1, 7, 0);
    total++; if (count !== 3) begin bad++; $display("FAIL basic_count got=%0d exp=3", count); end
    for (int i = 0; i < 3; i++) begin
      exp_v = 5 + i;
      total++; if (rd_data !== exp_v) begin bad++; $display("FAIL basic_rd%0d got=%0d exp=%0d", i, rd_data, exp_v); end
      cycle(0, '0, 1);
    end
    total++; if (empty !== 1'b1 || count !== 0) begin bad++; $display("FAIL basic_drain got=empty%0b/cnt%0d exp=empty1/cnt0", empty, count); end
  endtask

  task automatic test_full();
    logic [DW-1:0] exp_v;
    for (int i = 0; i < DEPTH; i++) cycle(1, i, 0);
    total++; if (full !== 1'b1 || count !== DEPTH) begin bad++; $display("FAIL full_fill got=full%0b/cnt%0d exp=full1/cnt%0d", full, count, DEPTH); end
    cycle(1, 99, 0);
    total++; if (count !== DEPTH || full !== 1'b1) begin bad++; $display("FAIL full_drop got=cnt%0d exp=%0d", count, DEPTH); end
`ifdef ARGO_FIFO_ERR_EN
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_overflow got=%0b exp=1", overflow); end
`endif
    for (int i = 0; i < DEPTH; i++) begin
      exp_v = i;
      total++; if (rd_data !== exp_v) begin bad++; $display("FAIL full_rd%0d got=%0d exp=%0d", i, rd_data, exp_v); end
      cycle(0, '0, 1);
    end
    total++; if (empty !== 1'b1 || rd_data !== '0) begin bad++; $display("FAIL full_after got=empty%0b/rd%0d exp=empty1/rd0", empty, rd_data); end
  endtask

  task automatic test_empty_read();
    do_reset();
    cycle(0, '0, 1);
    total++; if (rd_data !== '0 || count !== 0 || empty !== 1'b1) begin bad++; $display("FAIL uflow_state got=rd%0d/cnt%0d exp=rd0/cnt0", rd_data, count); end
`ifdef ARGO_FIFO_ERR_EN
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uflow_flag got=%0b exp=1", underflow); end
`endif
    // A write after the ignored pop must be the head, proving rp held still.
    cycle(1, 42, 1);
    total++; if (rd_data !== 42 || count !== 1) begin bad++; $display("FAIL uflow_nobypass got=rd%0d/cnt%0d exp=rd42/cnt1", rd_data, count); end
    cycle(0, '0, 1);
  endtask

  task automatic test_wrap();
    int nw = 0;
    int nr = 0;
    int occ;
    bit re, we;
    logic [DW-1:0] exp_v;
    for (int it = 0; it < 400 && nr < 40; it++) begin
      occ = q.size();
      re = (occ == 3) || (occ == 2 && ($urandom % 2) == 1) || (nw == 40 && occ > 0);
      we = (nw < 40) && (occ < 3 || re) && (occ == 0 || ($urandom % 4) != 0);
      if (re) begin
        exp_v = 100 + nr;
        total++; if (rd_data !== exp_v) begin bad++; $display("FAIL wrap_rd%0d got=%0d exp=%0d", nr, rd_data, exp_v); end
        nr++;
      end
      cycle(we, 100 + nw, re);
      if (we) nw++;
    end
    total++; if (nr != 40 || empty !== 1'b1) begin bad++; $display("FAIL wrap_done got=reads%0d/empty%0b exp=reads40/empty1", nr, empty); end
  endtask

  task automatic test_simul();
    logic [DW-1:0] exp_v;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 200 + i, 0);
    total++; if (rd_data !== 200) begin bad++; $display("FAIL simul4_head got=%0d exp=200", rd_data); end
    cycle(1, 204, 1);
    total++; if (count !== 4) begin bad++; $display("FAIL simul4_count got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      exp_v = 201 + i;
      total++; if (rd_data !== exp_v) begin bad++; $display("FAIL simul4_rd%0d got=%0d exp=%0d", i, rd_data, exp_v); end
      cycle(0, '0, 1);
    end
    for (int i = 0; i < DEPTH; i++) cycle(1, 300 + i, 0);
    total++; if (rd_data !== 300) begin bad++; $display("FAIL simulf_head got=%0d exp=300", rd_data); end
    cycle(1, 999, 1);
    total++; if (count !== DEPTH - 1 || full !== 1'b0) begin bad++; $display("FAIL simulf_count got=%0d exp=%0d", count, DEPTH - 1); end
    for (int i = 1; i < DEPTH; i++) begin
      exp_v = 300 + i;
      total++; if (rd_data !== exp_v) begin bad++; $display("FAIL simulf_rd%0d got=%0d exp=%0d", i, rd_data, exp_v); end
      cycle(0, '0, 1);
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL simulf_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) cycle(1, 500 + i, 0);
    total++; if (count !== 8) begin bad++; $display("FAIL rstmid_count got=%0d exp=8", count); end
    wr_en = 1'b1; wr_data = 77; rd_en = 1'b1;
    do_reset();
    total++; if (empty !== 1'b1 || count !== 0 || rd_data !== '0) begin bad++; $display("FAIL rstmid_state got=empty%0b/cnt%0d/rd%0d exp=1/0/0", empty, count, rd_data); end
  endtask

  task automatic test_random();
    bit we, re;
    logic [DW-1:0] exp_v;
    int wbias;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      wbias = (i < 200) ? 70 : 35;
      we = ($urandom % 100) < wbias;
      re = ($urandom % 100) < 50;
      exp_v = (q.size() > 0) ? q[0] : '0;
      total++; if (rd_data !== exp_v) begin bad++; $display("FAIL rand_rd_data@%0d got=%0d exp=%0d", i, rd_data, exp_v); end
      cycle(we, $urandom, re);
      total++;
      if (count !== q.size() || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
        bad++; $display("FAIL rand_flags@%0d got=cnt%0d/e%0b/f%0b exp=cnt%0d", i, count, empty, full, q.size());
      end
`ifdef ARGO_FIFO_ERR_EN
      total++; if (overflow !== ovf_m || underflow !== unf_m) begin bad++; $display("FAIL rand_err@%0d got=%0b%0b exp=%0b%0b", i, overflow, underflow, ovf_m, unf_m); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_empty_read();
    test_wrap();
    test_simul();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/argo_fifo.md
# argo_fifo

Synchronous single-clock FIFO used as the channel primitive between generated Argo control/data-flow processes. One writer pushes words with `wr_en`; one reader pops with `rd_en`. `full` and `empty` provide back-pressure. The head word is presented combinationally (first-word fall-through), so a consumer can capture `rd_data` on the same edge that pops it.

## Interface
- `ADDR_WIDTH`, default 4: pointer width. `DEPTH` must equal 2^`ADDR_WIDTH`.
- `DATA_WIDTH`, default 32: word width.
- `DEPTH`, default 16: capacity in words. Instantiated as `1<<ADDR_WIDTH`.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `rd_en`  in  1  pop request, sampled at `clk` rise.
- `rd_data`  out  `DATA_WIDTH`  head word, combinational from storage.
- `wr_en`  in  1  push request, sampled at `clk` rise.
- `wr_data`  in  `DATA_WIDTH`  word to push.
- `full`  out  1  high when count == `DEPTH`.
- `empty`  out  1  high when count == 0.
- `count`  out  `ADDR_WIDTH+1`  current occupancy, 0..`DEPTH`.

## Operation
- State:
  - Storage array of `DEPTH` x `DATA_WIDTH`.
  - Write pointer `wp` and read pointer `rp`, each `ADDR_WIDTH` bits.
  - Occupancy register `count`, `ADDR_WIDTH+1` bits.
- Pointers wrap modulo `DEPTH` by natural overflow (15 -> 0 at default size).
- Accepted write (`wr_en` && !`full`): mem[`wp`] <= `wr_data`; `wp` <= `wp`+1.
- Accepted read (`rd_en` && !`empty`): `rp` <= `rp`+1.
- `count` update:
  - +1 on a write only.
  - -1 on a read only.
  - Unchanged when both are accepted or neither is.
- Boundary rules:
  - Write while `full` is dropped. Storage, `wp` and `count` are unchanged. This holds even if a read is accepted on the same edge; `full` is evaluated from the pre-edge count.
  - Read while `empty` is ignored and `rp` is unchanged. A simultaneous write is still accepted; there is no bypass of a word into the same-cycle read.
- `rd_data`:
  - Equals mem[`rp`] when !`empty`.
  - Driven to 0 when `empty`.
- `full` and `empty` are decoded combinationally from `count`, never from pointer comparison.
- Reset (`rst` high at a clock edge):
  - `wp`=0, `rp`=0, `count`=0, so `empty`=1, `full`=0 and `rd_data`=0.
  - Storage contents are not cleared.
  - Reset overrides any simultaneous `rd_en`/`wr_en`; words in flight are discarded.

## Timing
- Write latency: a word written at edge N is visible on `rd_data` after edge N if the FIFO was empty, and `empty` falls after edge N.
- Read: `rd_data` is valid before the pop edge. The consumer samples `rd_data` on the same edge it asserts `rd_en`, and the next word appears after that edge.
- `full` rises after the edge accepting the `DEPTH`-th word; it falls after the first accepted read.
- Upstream logic may see flags up to two cycles late. Writers must re-check `full` before asserting `wr_en`; drop-on-full keeps the FIFO state consistent regardless.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- Macro `ARGO_FIFO_ERR_EN`. When defined, two extra outputs exist:
  - `overflow` (1 bit): sticky, set on any write attempted while `full`.
  - `underflow` (1 bit): sticky, set on any read attempted while `empty`.
  - Both are cleared only by `rst` and reset to 0.
- When not defined, these ports and their logic are absent. Dropped writes and ignored reads remain silent.

## Test plan
- Reset, then idle: `empty`=1, `full`=0, `count`=0, `rd_data`=0.
- Write 5,6,7 on consecutive cycles, then read 3 words: `rd_data` sequence is 5,6,7; `empty`=1 after the third pop; `count` returns to 0.
- Write 16 words 0..15 (default size): `full`=1 and `count`=16 after the 16th edge. A 17th write of 99 is dropped; reading 16 words returns 0..15 only. With `ARGO_FIFO_ERR_EN`, `overflow`=1.
- Read with `empty`=1: no pointer change and `rd_data` stays 0. With `ARGO_FIFO_ERR_EN`, `underflow`=1.
- Wrap-around: push/pop 40 words, values 100..139, interleaved while keeping occupancy 1-3. All 40 words come out in order.
- Simultaneous push and pop at count=4: `count` stays 4 and order is preserved. Simultaneous push and pop when full: the pop succeeds, the push is dropped, and `count`=15. Assert `rst` with count=8: `empty`=1 on the next cycle.
